// File: rtl/fpu_pkg.sv
// Shared definitions for the FP mantissa multiplier: field widths, the
// multiplier FSM state type and significand extraction.
package fpu_pkg;

  localparam int FLT_MANT_W = 23;
  localparam int FLT_SIG_W  = 24;
  localparam int FLT_PROD_W = 48;

  typedef enum logic [1:0] {
    MM_IDLE = 2'd0,
    MM_RUN  = 2'd1,
    MM_DONE = 2'd2
  } mm_state_t;

  // Significand with the hidden bit restored; the hidden bit is zero when the
  // exponent field is zero (zero / subnormal). Inf/NaN fields pass through.
  function automatic logic [FLT_SIG_W-1:0] sig_of(input logic [31:0] op);
    return {|op[30:23], op[FLT_MANT_W-1:0]};
  endfunction

endpackage

// File: rtl/fpu_mant_mult_if.sv
// Start/busy/done handshake and operand/result bus between EX-stage control
// (master) and the mantissa multiplier (slave).
interface fpu_mant_mult_if;
  import fpu_pkg::*;

  logic [31:0]           opa;
  logic [31:0]           opb;
  logic                  start;
  logic [FLT_PROD_W-1:0] mult_res;
  logic                  busy;
  logic                  done;

  modport master (
    output opa, opb, start,
    input  mult_res, busy, done
  );

  modport slave (
    input  opa, opb, start,
    output mult_res, busy, done
  );

endinterface

// File: rtl/fpu_mult_pp.sv
// Combinational partial product: 24-bit multiplicand times one RADIX-bit
// multiplier digit, built as a sum of shifted, gated copies of the multiplicand.
module fpu_mult_pp
  import fpu_pkg::*;
#(
  parameter int RADIX = 2
) (
  input  logic [FLT_SIG_W-1:0]       sig_a,
  input  logic [RADIX-1:0]           digit,
  output logic [FLT_SIG_W+RADIX-1:0] pp
);

  localparam int PP_W = FLT_SIG_W + RADIX;

  logic [PP_W-1:0] row [RADIX];

  generate
    for (genvar gi = 0; gi < RADIX; gi++) begin : g_row
      assign row[gi] = digit[gi] ? ({{RADIX{1'b0}}, sig_a} << gi) : '0;
    end
  endgenerate

  // Add the gated rows; the widest row still fits in PP_W bits.
  always_comb begin
    pp = '0;
    for (int i = 0; i < RADIX; i++) begin
      pp = pp + row[i];
    end
  end

endmodule

// File: rtl/fpu_mant_mult.sv
// Sequential 24x24 unsigned significand multiplier, RADIX multiplier bits
// retired per cycle by shift-add. Optional macro FPU_MULT_EARLY_OUT_EN: a
// zero significand on start skips RUN and completes in one cycle.
module fpu_mant_mult
  import fpu_pkg::*;
#(
  parameter int RADIX = 2   // 1,2,3,4,6 or 8
) (
  input  logic           clk,
  input  logic           rst,   // asynchronous, active-low
  fpu_mant_mult_if.slave mm
);

  localparam int N     = FLT_SIG_W / RADIX;
  localparam int CNT_W = $clog2(N + 1);
  localparam int PP_W  = FLT_SIG_W + RADIX;
  localparam int ACC_W = FLT_SIG_W + RADIX + 1;

  mm_state_t             state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg;
  logic [FLT_SIG_W-1:0]  sig_a_reg;
  logic [FLT_SIG_W-1:0]  mplier_reg;
  logic [ACC_W-1:0]      acc_reg;
  logic [FLT_PROD_W-1:0] mult_res_reg;

  logic [FLT_SIG_W-1:0]  start_sig_a;
  logic [FLT_SIG_W-1:0]  start_sig_b;
  logic                  accept;
  logic                  early_zero;
  logic                  last_iter;
  logic [PP_W-1:0]       pp;
  logic [ACC_W-1:0]      sum;
  logic [ACC_W-1:0]      acc_shifted;
  logic [FLT_SIG_W-1:0]  mplier_shifted;

  assign start_sig_a = sig_of(mm.opa);
  assign start_sig_b = sig_of(mm.opb);

  // A new operation may only begin when no multiply is in flight.
  assign accept    = mm.start && (state_reg != MM_RUN);
  assign last_iter = (cnt_reg == CNT_W'(N - 1));

`ifdef FPU_MULT_EARLY_OUT_EN
  assign early_zero = (start_sig_a == '0) || (start_sig_b == '0);
`else
  assign early_zero = 1'b0;
`endif

  fpu_mult_pp #(
    .RADIX (RADIX)
  ) u_pp (
    .sig_a (sig_a_reg),
    .digit (mplier_reg[RADIX-1:0]),
    .pp    (pp)
  );

  // {acc, mplier} is one double-width register shifted right by RADIX per
  // iteration; the low bits of the new sum drop into the vacated multiplier bits.
  assign sum            = acc_reg + ACC_W'(pp);
  assign acc_shifted    = sum >> RADIX;
  assign mplier_shifted = {sum[RADIX-1:0], mplier_reg[FLT_SIG_W-1:RADIX]};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= MM_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: DONE lasts one cycle unless a new start chains directly.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      MM_IDLE, MM_DONE: begin
        if (accept) begin
          state_next = early_zero ? MM_DONE : MM_RUN;
        end else begin
          state_next = MM_IDLE;
        end
      end
      MM_RUN: begin
        if (last_iter) begin
          state_next = MM_DONE;
        end
      end
      default: state_next = MM_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, iterate in RUN, publish on the last step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg      <= '0;
      sig_a_reg    <= '0;
      mplier_reg   <= '0;
      acc_reg      <= '0;
      mult_res_reg <= '0;
    end else if (state_reg == MM_RUN) begin
      acc_reg    <= acc_shifted;
      mplier_reg <= mplier_shifted;
      cnt_reg    <= cnt_reg + 1'b1;
      if (last_iter) begin
        mult_res_reg <= {acc_shifted[FLT_SIG_W-1:0], mplier_shifted};
      end
    end else if (accept) begin
      sig_a_reg  <= start_sig_a;
      mplier_reg <= start_sig_b;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      if (early_zero) begin
        mult_res_reg <= '0;
      end
    end
  end

  assign mm.mult_res = mult_res_reg;
  assign mm.busy     = (state_reg == MM_RUN);
  assign mm.done     = (state_reg == MM_DONE);

endmodule
